// File: rtl/pwm_audio_out.sv
// PWM audio output stage: PCM samples enter a small FIFO through valid/ready,
// and one sample is loaded as the PWM duty at each period boundary.

module pwm_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; level and pointers alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

module pwm_audio_out #(
    parameter int WIDTH      = 8,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int SIGNED_IN  = 0
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          period_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]     PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0]  MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
    // Flipping the MSB maps two's complement onto offset binary.
    localparam logic [WIDTH-1:0]  IN_XOR   = (SIGNED_IN != 0) ? MIDSCALE : '0;

    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             tick;
    logic             boundary;
    logic             push;
    logic             pop;

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;
    assign tick         = en && (prescaler == PRE_MAX);
    assign boundary     = tick && (counter == '1);
    assign pop          = boundary && !fifo_empty;

    pwm_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (sample_in ^ IN_XOR),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Disabling parks the timebase at zero so re-enable starts a clean period.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            counter   <= '0;
        end else if (!en) begin
            prescaler <= '0;
            counter   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                counter <= counter + 1'b1;
        end
    end

    // Duty only changes at the wrap; an empty FIFO keeps the last level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty         <= MIDSCALE;
            period_start <= 1'b0;
            underrun     <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            if (pop)
                duty <= fifo_head;
            period_start <= boundary;
            underrun     <= boundary && fifo_empty;
            pwm_out      <= en && (counter < duty);
        end
    end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Parametrised PWM audio output stage. Next generation of the single-counter PWM used after the microphone/PCM capture path.
- Accepts PCM samples through a valid/ready handshake into a small FIFO.
- Loads one sample per PWM period, so duty changes never glitch mid-period.
- Adds a clock prescaler, signed-input conversion, underrun reporting and an enable.

Parameters:
- WIDTH, 8, sample and duty width in bits. PWM period = 2^WIDTH ticks.
- CLK_DIV, 1, clk_in cycles per counter tick (>=1).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).
- SIGNED_IN, 0, 1: sample_in is two's complement and is converted to offset binary by inverting its MSB at push.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable.
- sample_in  in  WIDTH  PCM sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  FIFO can accept a sample.
- pwm_out  out  1  registered PWM signal.
- period_start  out  1  one-cycle pulse when a new period begins and duty is reloaded.
- underrun  out  1  one-cycle pulse when a period starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held.

Behaviour:
- Interface: one clock, clk_in. rst is asynchronous, active-high.
- Reset values:
  - pwm_out=0, period_start=0, underrun=0.
  - prescaler=0, counter=0.
  - FIFO empty, fifo_level=0.
  - duty=2^(WIDTH-1) (midscale, avoids pop at start).
  - sample_ready=1 once rst is released.
- Push: occurs when sample_valid && sample_ready. sample_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
- Stored value: sample_in with MSB inverted if SIGNED_IN=1, otherwise sample_in unchanged.
- Prescaler: counts 0..CLK_DIV-1 while en=1. tick = en && prescaler==CLK_DIV-1. With CLK_DIV=1, tick = en.
- Counter: WIDTH bits, increments on tick, wraps 2^WIDTH-1 -> 0.
- Period boundary, same edge as the wrap (tick && counter==2^WIDTH-1):
  - FIFO non-empty: duty <= FIFO head, pop, period_start=1.
  - FIFO empty: duty holds its last value, period_start=1, underrun=1.
- Output: pwm_out <= en && (counter < duty), evaluated every clk_in edge from registered counter/duty. One-cycle latency behind counter.
  - duty=0 -> constantly 0.
  - duty=2^WIDTH-1 -> high 2^WIDTH-1 of 2^WIDTH ticks.
- en=0:
  - prescaler and counter are forced to 0 synchronously; pwm_out=0 next edge.
  - No pops, no period_start, no underrun.
  - Pushes still accepted.
  - duty retained.
  - On re-enable the first period uses the retained duty. The first reload happens at the end of that period.
- Simultaneous push and pop (FIFO neither empty nor full): both performed, fifo_level unchanged.
- FIFO full: sample_ready=0, and it stays low during a same-cycle pop (no bypass).
- FIFO empty with a push on the boundary cycle: pop sees empty -> underrun. The pushed sample is stored and used at the next boundary.
- rst mid-period: everything returns immediately to reset values. Queued samples are discarded.
- Sample_in with no handshake: ignored. sample_in may change freely while sample_valid=0.
- Outputs period_start and underrun are registered pulses, high exactly one clk_in cycle per event.

Test Plan:
- Reset/idle (WIDTH=4, CLK_DIV=1): release rst, en=1, no samples. Required:
  - pwm_out high 8 of every 16 cycles (midscale).
  - underrun and period_start pulse every 16 cycles.
  - fifo_level=0.
- Duty sweep: push 0, 1, 15, 8 before the first boundary. Required:
  - Successive periods show pwm_out high for 0, 1, 15 and 8 cycles.
  - fifo_level decrements at each period_start.
  - No underrun until the FIFO drains.
- Backpressure (FIFO_DEPTH=4): hold sample_valid=1 for 6 cycles. Required:
  - Exactly 4 accepted, sample_ready=0, fifo_level=4.
  - At the next period_start: level 3 and sample_ready=1 the cycle after.
- Signed mode (SIGNED_IN=1, WIDTH=4): push 4'b1000 (-8), then 4'b0111 (+7). Required: duty 0 then 15, giving high 0 then 15 cycles per period.
- Prescaler/enable (CLK_DIV=3, duty 4): Required:
  - pwm_out high 12 clk_in cycles per 48-cycle period.
  - Dropping en mid-period gives pwm_out=0 next edge and counter=0.
  - Re-enable restarts the period at counter 0.
- Async reset mid-operation: assert rst between clock edges with 3 queued samples and pwm_out=1. Required:
  - pwm_out=0, fifo_level=0 immediately, without waiting for an edge.
  - After release, midscale output resumes.
